// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with a valid/ready handshake.
// The carry chain is split into STAGES chunks of CHUNK bits. Each stage adds
// one chunk, using the carry registered by the previous stage. The operand
// bits still to be added travel up the pipeline in shrinking skew registers,
// and the finished low sum bits travel in growing ones.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Signed overflow: both addends share a sign and the result's sign differs.
   function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // The whole pipeline moves as one unit. A stalled output freezes every stage.
   assign advance  = out_ready || !out_valid;
   // The pipeline is empty during reset, so the block reports ready.
   // Nothing is captured while rst is high, because rst wins in the valid registers.
   assign in_ready = advance || rst;

   // Subtraction is a + ~b + 1. The +1 enters as the stage-0 carry.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int HI = WIDTH - (k + 1) * CHUNK;
      localparam int LO = (k + 1) * CHUNK;

      logic [CHUNK-1:0] a_c;
      logic [CHUNK-1:0] b_c;
      logic             c_in;
      logic             v_in;
      logic             am_in;
      logic             bm_in;
      logic [CHUNK:0]   part;
      logic [LO-1:0]    s_in;

      logic             vld_p;
      logic             cy_p;
      logic             am_p;
      logic             bm_p;
      logic [LO-1:0]    s_p;

      assign part = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, c_in};

      if (k == 0) begin : g_src
         assign a_c   = a[CHUNK-1:0];
         assign b_c   = b_eff[CHUNK-1:0];
         assign c_in  = c0;
         assign v_in  = in_valid;
         assign am_in = a[WIDTH-1];
         assign bm_in = b_eff[WIDTH-1];
         assign s_in  = part[CHUNK-1:0];
      end else begin : g_src
         assign a_c   = g_stg[k-1].g_hi.a_hi_p[CHUNK-1:0];
         assign b_c   = g_stg[k-1].g_hi.b_hi_p[CHUNK-1:0];
         assign c_in  = g_stg[k-1].cy_p;
         assign v_in  = g_stg[k-1].vld_p;
         assign am_in = g_stg[k-1].am_p;
         assign bm_in = g_stg[k-1].bm_p;
         assign s_in  = {part[CHUNK-1:0], g_stg[k-1].s_p};
      end

      if (HI > 0) begin : g_hi
         logic [HI-1:0] a_hi_p;
         logic [HI-1:0] b_hi_p;

         if (k == 0) begin : g_cap
            // Capture the operand chunks that later stages still have to add.
            always_ff @(posedge clk) begin
               if (advance) begin
                  a_hi_p <= a[WIDTH-1:CHUNK];
                  b_hi_p <= b_eff[WIDTH-1:CHUNK];
               end
            end
         end else begin : g_cap
            // Pass the remaining operand chunks along and drop the chunk consumed here.
            always_ff @(posedge clk) begin
               if (advance) begin
                  a_hi_p <= g_stg[k-1].g_hi.a_hi_p[HI+CHUNK-1:CHUNK];
                  b_hi_p <= g_stg[k-1].g_hi.b_hi_p[HI+CHUNK-1:CHUNK];
               end
            end
         end
      end

      // Stage valid bit: cleared by reset, shifted on advance.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_p <= 1'b0;
         end else if (advance) begin
            vld_p <= v_in;
         end
      end

      // The chunk carry, the partial sum and the operand sign bits move with the operation.
      always_ff @(posedge clk) begin
         if (advance) begin
            cy_p <= part[CHUNK];
            am_p <= am_in;
            bm_p <= bm_in;
            s_p  <= s_in;
         end
      end
   end

   // Result flags are gated by out_valid, so all outputs read as zero after reset.
   assign out_valid = g_stg[LAST].vld_p;
   assign sum       = out_valid ? g_stg[LAST].s_p : '0;
   assign cout      = out_valid && g_stg[LAST].cy_p;
   assign ovf       = out_valid && ovf_f(g_stg[LAST].am_p, g_stg[LAST].bm_p,
                                         g_stg[LAST].s_p[WIDTH-1]);
   assign zero      = out_valid && (g_stg[LAST].s_p == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub.
// Three instances (STAGES = 4, 1, 32) share one operand stream. Each instance
// has its own out_ready and its own ordered list of expected results.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        cin;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;

   logic        iry  [3];
   logic        ordy [3];
   logic        ov   [3];
   logic        co   [3];
   logic        of   [3];
   logic        zr   [3];
   logic [31:0] sm   [3];

   // Hand-computed vector table.
   logic [31:0] ta [24];
   logic [31:0] tb_b [24];
   logic [31:0] te [24];
   logic        tcin [24];
   logic        tsub [24];
   logic        tco [24];
   logic        tov [24];
   logic        tz [24];

   int checks = 0;
   int errors = 0;
   int cur_idx;
   int acc [3][64];
   int wr [3];
   int rd [3];
   int run [3];
   int maxrun [3];
   int lat [3];

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_s4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iry[0]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
      .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

   pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iry[1]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
      .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

   pipelined_addsub #(.WIDTH(32), .STAGES(32)) u_s32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iry[2]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
      .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic setv(input int i, input logic [31:0] va, input logic [31:0] vb,
                       input logic vcin, input logic vsub, input logic [31:0] vs,
                       input logic vco, input logic vov, input logic vz);
      ta[i] = va; tb_b[i] = vb; tcin[i] = vcin; tsub[i] = vsub;
      te[i] = vs; tco[i] = vco; tov[i] = vov; tz[i] = vz;
   endtask

   // Present one vector and hold it until the STAGES=4 instance takes it.
   task automatic send(input int idx);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      cur_idx  = idx;
      a        = ta[idx];
      b        = tb_b[idx];
      cin      = tcin[idx];
      sub      = tsub[idx];
      in_valid = 1'b1;
      while (!got && n < 50) begin
         #4;
         if (iry[0] && !rst) got = 1'b1;
         @(posedge clk);
         #2;
         n++;
      end
      check($sformatf("accept_v%0d", idx), 32'(got), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Called just after send() returns, with the pipelines otherwise empty.
   task automatic lat_check(input string tag);
      int first [3];
      for (int j = 0; j < 3; j++) first[j] = -1;
      for (int c = 1; c <= 40; c++) begin
         for (int j = 0; j < 3; j++)
            if (ov[j] && first[j] < 0) first[j] = c;
         @(posedge clk);
         #2;
      end
      for (int j = 0; j < 3; j++)
         check($sformatf("%s_lat_s%0d", tag, lat[j]), 32'(first[j]), 32'(lat[j]));
   endtask

   // Scoreboard: retire and compare on each output handshake, record each input handshake.
   always @(negedge clk) begin
      int idx;
      for (int j = 0; j < 3; j++) begin
         if (rst) begin
            wr[j]  = 0;
            rd[j]  = 0;
            run[j] = 0;
         end else begin
            if (ov[j]) run[j]++;
            else run[j] = 0;
            if (run[j] > maxrun[j]) maxrun[j] = run[j];
            if (ov[j] && ordy[j]) begin
               if (rd[j] >= wr[j]) begin
                  check($sformatf("s%0d_spurious_valid", lat[j]), 32'(ov[j]), 32'd0);
               end else begin
                  idx = acc[j][rd[j] % 64];
                  check($sformatf("s%0d_v%0d_sum", lat[j], idx), sm[j], te[idx]);
                  check($sformatf("s%0d_v%0d_cout", lat[j], idx), 32'(co[j]), 32'(tco[idx]));
                  check($sformatf("s%0d_v%0d_ovf", lat[j], idx), 32'(of[j]), 32'(tov[idx]));
                  check($sformatf("s%0d_v%0d_zero", lat[j], idx), 32'(zr[j]), 32'(tz[idx]));
                  rd[j]++;
               end
            end
            if (in_valid && iry[j]) begin
               acc[j][wr[j] % 64] = cur_idx;
               wr[j]++;
            end
         end
      end
   end

   initial begin
      //   idx  a             b             cin   sub   sum           cout  ovf   zero
      setv(0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      setv(1,  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      setv(2,  32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      setv(3,  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      setv(4,  32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0);
      setv(5,  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
      setv(6,  32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      setv(7,  32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
      setv(8,  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
      setv(9,  32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0, 1'b0);
      setv(10, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0);
      setv(11, 32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      setv(12, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
      setv(13, 32'h00000010, 32'h00000020, 1'b1, 1'b0, 32'h00000031, 1'b0, 1'b0, 1'b0);
      setv(14, 32'h00000100, 32'h00000001, 1'b0, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0);
      setv(15, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      setv(16, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
      setv(17, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      setv(18, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
      setv(19, 32'h00000003, 32'h00000002, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0);
      setv(20, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
      setv(21, 32'h00000002, 32'h00000002, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0);
      setv(22, 32'h00000003, 32'h00000003, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0);
      setv(23, 32'h00001000, 32'h00000001, 1'b0, 1'b1, 32'h00000FFF, 1'b1, 1'b0, 1'b0);

      lat[0] = 4; lat[1] = 1; lat[2] = 32;
      for (int j = 0; j < 3; j++) begin
         ordy[j] = 1'b1; wr[j] = 0; rd[j] = 0; run[j] = 0; maxrun[j] = 0;
      end
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; cur_idx = 0;

      // Reset state
      @(posedge clk); #3;
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_rdy_in_rst", lat[j]), 32'(iry[j]), 32'd1);
      @(posedge clk); #3;
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_rst_ov", lat[j]), 32'(ov[j]), 32'd0);
      check("rst_sum", sm[0], 32'd0);
      check("rst_flags", {29'd0, co[0], of[0], zr[0]}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Carry through every chunk, latency on all three depths
      send(0);
      lat_check("wrap");

      // Signed overflow and borrow corner cases
      send(1); send(2); send(3);
      idle(40);

      // Back-to-back stream
      for (int j = 0; j < 3; j++) maxrun[j] = 0;
      for (int i = 4; i < 12; i++) send(i);
      idle(40);
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_b2b_run", lat[j]), 32'(maxrun[j]), 32'd8);

      // Output stall with the STAGES=4 pipeline full
      ordy[0] = 1'b0;
      for (int i = 12; i < 16; i++) send(i);
      fork
         begin
            for (int i = 16; i < 20; i++) send(i);
         end
         begin
            #1;
            for (int c = 0; c < 5; c++) begin
               check("stall_in_ready", 32'(iry[0]), 32'd0);
               check("stall_out_valid", 32'(ov[0]), 32'd1);
               check("stall_sum", sm[0], te[12]);
               if (c < 4) begin
                  @(posedge clk); #3;
               end
            end
            @(posedge clk); #2;
            ordy[0] = 1'b1;
         end
      join
      idle(40);

      // Reset with three operations in flight; operands offered during reset are refused
      send(20); send(21); send(22);
      rst = 1'b1;
      cur_idx = 23; a = ta[23]; b = tb_b[23]; cin = tcin[23]; sub = tsub[23]; in_valid = 1'b1;
      #1;
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_rdy_during_rst", lat[j]), 32'(iry[j]), 32'd1);
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_ov_after_rst", lat[j]), 32'(ov[j]), 32'd0);
      check("after_rst_sum", sm[0], 32'd0);
      check("after_rst_flags", {29'd0, co[0], of[0], zr[0]}, 32'd0);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int j = 0; j < 3; j++) check($sformatf("s%0d_quiet_after_rst", lat[j]), 32'(ov[j]), 32'd0);
      end
      @(posedge clk); #2;
      send(23);
      lat_check("post_rst");

      // Every accepted operation was retired exactly once
      for (int j = 0; j < 3; j++) check($sformatf("s%0d_drained", lat[j]), 32'(rd[j]), 32'(wr[j]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; WIDTH % STAGES == 0, STAGES >= 1; CHUNK = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used in add mode only.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Add: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-018 Subtract: {cout,sum} = a + ~b + 1; cin ignored; cout = 1 means no borrow (a >= b unsigned).
REQ-019 ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), b_eff = sub ? ~b : b.
REQ-020 Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (stage 0 uses cin or sub); upper operand chunks and lower sum chunks travel in skew registers with the operation.
REQ-021 No combinational carry path spans more than CHUNK bits.
REQ-022 Each stage holds a valid bit; advance = out_ready || !out_valid; all stages shift together when advance is 1 and hold otherwise.
REQ-023 in_ready = advance; operands captured when in_valid && in_ready.
REQ-024 Latency: an operation accepted in cycle t appears with out_valid = 1 in cycle t+STAGES when advance stays 1.
REQ-025 Throughput: one operation per cycle sustained while out_ready = 1.
REQ-026 Bubbles (in_valid = 0 while advancing) propagate as invalid stages; out_valid = 0 for them.
REQ-027 While out_valid && !out_ready: sum, cout, ovf, zero and out_valid stay stable; no operation lost or duplicated.
REQ-028 Accept-and-retire in the same cycle is permitted when out_ready = 1.
REQ-029 Results leave in acceptance order.
REQ-030 sum, cout, ovf, zero are don't-care when out_valid = 0.
REQ-031 STAGES = 1: single registered adder, latency 1, same handshake.

Reset
REQ-032 rst = 1 at a clock edge clears all stage valid bits; out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0 on the following cycle.
REQ-033 rst discards in-flight operations; none reappear after reset.
REQ-034 in_ready = 1 during and after reset (pipeline empty); operands presented while rst = 1 are not accepted.
REQ-035 rst has priority over all handshake activity in the same cycle.

Verification (WIDTH = 32, STAGES = 4)
REQ-036 Add a=FFFFFFFF, b=00000001, cin=0, out_ready=1 -> 4 cycles later sum=00000000, cout=1, zero=1, ovf=0.
REQ-037 Add a=7FFFFFFF, b=00000001 -> sum=80000000, ovf=1, cout=0; sub a=00000005, b=00000007 -> sum=FFFFFFFE, cout=0, ovf=0; sub a=80000000, b=00000001 -> sum=7FFFFFFF, ovf=1, cout=1.
REQ-038 Back-to-back 8 random ops, out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching a reference model.
REQ-039 Stream ops, out_ready held 0 for 5 cycles with pipeline full -> in_ready=0, outputs stable; out_ready=1 -> stream resumes, no loss/duplication.
REQ-040 3 ops in flight, rst pulsed 1 cycle -> out_valid=0 next cycle and stays 0 until a new op completes 4 cycles after acceptance.
REQ-041 Repeat REQ-036/038 with STAGES=1 and STAGES=32, WIDTH=32 -> latency 1 and 32 respectively, identical results.
